// File: rtl/hcms_pkg.sv
// Shared definitions for the HCMS-29xx serial display transmitter.
package hcms_pkg;

  localparam int unsigned HCMS_DATA_W_DEF       = 8;
  localparam int unsigned HCMS_CLK_DIV_DEF      = 2;
  localparam int unsigned HCMS_RESET_CYCLES_DEF = 16;

  // Transmitter states
  typedef enum logic [2:0] {
    PWR_RST   = 3'd0,
    IDLE      = 3'd1,
    SHIFT_LO  = 3'd2,
    SHIFT_HI  = 3'd3,
    WAIT_NEXT = 3'd4,
    END_HOLD  = 3'd5,
    GAP       = 3'd6
  } hcms_state_e;

  // Control-word layout: bit 7 selects control register 0 or 1
  localparam int unsigned HCMS_CTRL_W    = 8;
  localparam logic        HCMS_SEL_CTRL0 = 1'b0;
  localparam logic        HCMS_SEL_CTRL1 = 1'b1;

  // Control register 0 peak-current field encodings
  localparam logic [1:0] HCMS_PEAK_73  = 2'b00;
  localparam logic [1:0] HCMS_PEAK_50  = 2'b01;
  localparam logic [1:0] HCMS_PEAK_100 = 2'b10;
  localparam logic [1:0] HCMS_PEAK_93  = 2'b11;

  // Control register 0 brightness (PWM duty) limits
  localparam logic [3:0] HCMS_BRIGHT_MIN = 4'h0;
  localparam logic [3:0] HCMS_BRIGHT_MAX = 4'hF;

  typedef struct packed {
    logic       sel;
    logic       n_sleep;
    logic [1:0] peak;
    logic [3:0] bright;
  } hcms_ctrl0_t;

  typedef struct packed {
    logic       sel;
    logic [4:0] rsvd;
    logic       osc_prescale;
    logic       dout_simul;
  } hcms_ctrl1_t;

  // Build an awake control-register-0 word from peak current and brightness
  function automatic logic [HCMS_CTRL_W-1:0] hcms_ctrl0_word(input logic [1:0] peak,
                                                              input logic [3:0] bright);
    hcms_ctrl0_t w;
    w.sel     = HCMS_SEL_CTRL0;
    w.n_sleep = 1'b1;
    w.peak    = peak;
    w.bright  = bright;
    return w;
  endfunction

  // Build a control-register-1 word
  function automatic logic [HCMS_CTRL_W-1:0] hcms_ctrl1_word(input logic osc_prescale,
                                                              input logic dout_simul);
    hcms_ctrl1_t w;
    w.sel          = HCMS_SEL_CTRL1;
    w.rsvd         = 5'd0;
    w.osc_prescale = osc_prescale;
    w.dout_simul   = dout_simul;
    return w;
  endfunction

endpackage

// File: rtl/hcms_tick_gen.sv
// Half-period tick generator: tick every CLK_DIV cycles, restartable.
module hcms_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic r_reset,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned    CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = !restart && (cnt == CNT_MAX);

  // Count cycles within a half period; restart holds the count at zero
  always_ff @(posedge i_clk or posedge r_reset) begin
    if (r_reset) begin
      cnt <= '0;
    end else if (restart || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hcms_frame_tx.sv
// Serial frame transmitter driving an HCMS-29xx display, every pin from a flop.
module hcms_frame_tx
  import hcms_pkg::*;
#(
  parameter int unsigned DATA_W       = HCMS_DATA_W_DEF,
  parameter int unsigned CLK_DIV      = HCMS_CLK_DIV_DEF,
  parameter int unsigned RESET_CYCLES = HCMS_RESET_CYCLES_DEF
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_cmd,
  input  logic              i_disp_reset,
  output logic              o_frame_done,
  output logic              o_hcms_data,
  output logic              o_hcms_clock,
  output logic              o_hcms_regsel,
  output logic              o_hcms_ncs,
  output logic              o_hcms_reset
);

  localparam int unsigned      BIT_W    = $clog2(DATA_W);
  localparam int unsigned      RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

  hcms_state_e       state, state_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [RST_W-1:0]  rst_cnt, rst_cnt_nxt;
  logic              last_q, last_nxt;

  logic ready_nxt, clock_nxt, ncs_nxt, hreset_nxt, done_nxt, data_nxt, regsel_nxt;
  logic accept, tick, restart;

  // A display-reset request in IDLE takes priority over an offered word
  assign accept  = i_valid && o_ready && !((state == IDLE) && i_disp_reset);
  assign restart = (state == PWR_RST) || (state == IDLE) || (state == WAIT_NEXT);

  hcms_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk   (i_CLK),
    .r_reset (i_RST),
    .restart (restart),
    .tick_c  (tick)
  );

  // State register
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state <= PWR_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath-next logic
  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    rst_cnt_nxt = rst_cnt;
    last_nxt    = last_q;
    case (state)
      PWR_RST: begin
        if (rst_cnt == RST_LAST) begin
          state_nxt   = IDLE;
          rst_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + RST_W'(1);
        end
      end
      IDLE: begin
        if (i_disp_reset) begin
          state_nxt   = PWR_RST;
          rst_cnt_nxt = '0;
        end else if (accept) begin
          state_nxt   = SHIFT_LO;
          sreg_nxt    = i_data;
          last_nxt    = i_last;
          bit_cnt_nxt = '0;
        end
      end
      SHIFT_LO: begin
        if (tick) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt == BIT_LAST) begin
            state_nxt   = last_q ? END_HOLD : WAIT_NEXT;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt   = SHIFT_LO;
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
            sreg_nxt    = {sreg[DATA_W-2:0], 1'b0};
          end
        end
      end
      WAIT_NEXT: begin
        if (accept) begin
          state_nxt   = SHIFT_LO;
          sreg_nxt    = i_data;
          last_nxt    = i_last;
          bit_cnt_nxt = '0;
        end
      end
      END_HOLD: begin
        if (tick) state_nxt = GAP;
      end
      GAP: begin
        if (tick) state_nxt = IDLE;
      end
      default: begin
        state_nxt = PWR_RST;
      end
    endcase
  end

  // Pin values for the coming cycle, derived from the next state
  always_comb begin
    ready_nxt  = (state_nxt == IDLE) || (state_nxt == WAIT_NEXT);
    clock_nxt  = (state_nxt == SHIFT_HI);
    ncs_nxt    = (state_nxt == PWR_RST) || (state_nxt == IDLE) || (state_nxt == GAP);
    hreset_nxt = (state_nxt != PWR_RST);
    done_nxt   = (state == END_HOLD) && (state_nxt == GAP);
    data_nxt   = sreg_nxt[DATA_W-1];
    regsel_nxt = o_hcms_regsel;
    if ((state == IDLE) && accept) regsel_nxt = i_cmd;
  end

  // Shift register and counters
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      sreg    <= '0;
      bit_cnt <= '0;
      rst_cnt <= '0;
      last_q  <= 1'b0;
    end else begin
      sreg    <= sreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      rst_cnt <= rst_cnt_nxt;
      last_q  <= last_nxt;
    end
  end

  // Output flops; reset parks the display deselected and held in reset
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      o_ready       <= 1'b0;
      o_frame_done  <= 1'b0;
      o_hcms_data   <= 1'b0;
      o_hcms_clock  <= 1'b0;
      o_hcms_regsel <= 1'b0;
      o_hcms_ncs    <= 1'b1;
      o_hcms_reset  <= 1'b0;
    end else begin
      o_ready       <= ready_nxt;
      o_frame_done  <= done_nxt;
      o_hcms_data   <= data_nxt;
      o_hcms_clock  <= clock_nxt;
      o_hcms_regsel <= regsel_nxt;
      o_hcms_ncs    <= ncs_nxt;
      o_hcms_reset  <= hreset_nxt;
    end
  end

endmodule

// File: doc/hcms_frame_tx.md
HCMS_FRAME_TX -- requirements
Module: hcms_frame_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per word shifted MSB first (legal >=2).
REQ-002 SHALL have parameter CLK_DIV, default 2, i_CLK cycles per serial-clock half period (legal >=1).
REQ-003 SHALL have parameter RESET_CYCLES, default 16, i_CLK cycles o_hcms_reset is held low per display reset (legal >=1).
REQ-004 SHALL have port i_CLK  in  1  system clock; one clock; all logic on rising edge.
REQ-005 SHALL have port i_RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_valid  in  1  word offered.
REQ-007 SHALL have port o_ready  out  1  word can be accepted this cycle.
REQ-008 SHALL have port i_data  in  DATA_W  word to shift.
REQ-009 SHALL have port i_last  in  1  word ends the frame (nCE released after it).
REQ-010 SHALL have port i_cmd  in  1  register select for the frame (1 control, 0 dot).
REQ-011 SHALL have port i_disp_reset  in  1  request a display reset pulse.
REQ-012 SHALL have port o_frame_done  out  1  one-cycle pulse when a frame's nCE rises.
REQ-013 SHALL have ports o_hcms_data, o_hcms_clock, o_hcms_regsel, o_hcms_ncs, o_hcms_reset  out  1 each  display pins; o_hcms_ncs and o_hcms_reset active-low.

Function
REQ-014 SHALL implement states PWR_RST, IDLE, SHIFT_LO, SHIFT_HI, WAIT_NEXT, END_HOLD, GAP.
REQ-015 SHALL drive every display pin from a flop; no gated or derived clocks; o_hcms_clock idles low.
REQ-016 SHALL accept a word on the cycle i_valid && o_ready; o_ready high only in IDLE and WAIT_NEXT.
REQ-017 In IDLE, on accept at edge k: from k+1 o_hcms_ncs=0, o_hcms_data=i_data[DATA_W-1], o_hcms_regsel=i_cmd (latched for whole frame), state SHIFT_LO.
REQ-018 SHIFT_LO lasts CLK_DIV cycles with clock low, then SHIFT_HI lasts CLK_DIV cycles with clock high; next bit presented at the high-to-low transition; word takes 2*DATA_W*CLK_DIV cycles.
REQ-019 After SHIFT_HI of the last bit: i_last of that word set -> END_HOLD; clear -> WAIT_NEXT.
REQ-020 WAIT_NEXT: nCE stays low, clock low, o_ready=1; accept -> load next word, MSB on data next cycle, SHIFT_LO; i_cmd ignored (frame-latched).
REQ-021 END_HOLD: CLK_DIV cycles clock low, nCE low; then o_hcms_ncs=1 and o_frame_done=1 for one cycle, enter GAP.
REQ-022 GAP: CLK_DIV cycles nCE high, o_ready=0, then IDLE.
REQ-023 i_disp_reset sampled only in IDLE; if asserted with i_valid in the same cycle, reset wins, word not accepted.
REQ-024 Display reset: o_hcms_reset=0, o_hcms_ncs=1, clock 0 for RESET_CYCLES cycles (state PWR_RST), then IDLE; o_ready=0 throughout.
REQ-025 i_disp_reset asserted outside IDLE SHALL be ignored (not queued).
REQ-026 Bit and half-period counters SHALL be sized $clog2 of their ranges and not wrap inside a word; word count per frame unbounded.

Reset
REQ-027 While i_RST high: o_hcms_ncs=1, o_hcms_clock=0, o_hcms_data=0, o_hcms_regsel=0, o_hcms_reset=0, o_ready=0, o_frame_done=0, state PWR_RST, counters 0.
REQ-028 After i_RST falls, block SHALL complete a full RESET_CYCLES display reset before first IDLE.
REQ-029 i_RST mid-frame SHALL abort immediately; partial frame discarded, no o_frame_done.

Structure
REQ-030 Package hcms_pkg SHALL hold state encodings, default parameter values, and HCMS control-word constants (CTRL0/CTRL1 select bit, brightness/peak-current fields).
REQ-031 Half-period tick generator SHALL be sub-module hcms_tick_gen (CLK_DIV counter, restart input, tick output).

Verification
REQ-032 Reset release, RESET_CYCLES=16 -> o_hcms_reset low exactly 16 cycles after i_RST falls, o_ready rises on following cycle.
REQ-033 DATA_W=8, CLK_DIV=2, single word 0xA5, i_cmd=1, i_last=1 -> 8 rising clocks sample 1,0,1,0,0,1,0,1; regsel=1; nCE low 32+2 cycles; one o_frame_done pulse.
REQ-034 Two-word frame 0x81 (i_last=0) then 0x7D (i_last=1) presented 5 cycles late -> nCE stays low across gap, 16 rising clocks, clock low during WAIT_NEXT.
REQ-035 i_disp_reset and i_valid together in IDLE -> reset pulse, o_ready low, word not consumed; word accepted after IDLE returns.
REQ-036 i_RST asserted at bit 3 of a word -> next cycle nCE=1, clock=0, no o_frame_done, full reset sequence follows.
REQ-037 CLK_DIV=1, DATA_W=16, back-to-back frames -> 32-cycle words, GAP of exactly 1 cycle with nCE high between frames.
